// File: rtl/mby_gmm_pkg.sv
// Shared types for the GCM shared-memory watermark path: broadcast struct,
// hysteresis state encoding and default sizing.
package mby_gmm_pkg;

  localparam int GMM_NUM_PORTS = 16;
  localparam int GMM_CNT_W     = 16;

  typedef enum logic {
    NORMAL    = 1'b0,
    CONGESTED = 1'b1
  } wm_state_e;

  typedef struct packed {
    logic                     valid;
    logic [GMM_NUM_PORTS-1:0] port_wm;
    logic                     shared_wm;
  } mby_cm_shared_mem_rx_wm_t;

endpackage

// File: rtl/mby_gcm_wm_hyst.sv
// One saturating segment counter with its hysteresis FSM. The counter updates
// one edge after the event; the FSM compares the registered count one edge later.
module mby_gcm_wm_hyst
  import mby_gmm_pkg::*;
#(
  parameter int CNT_W = GMM_CNT_W,
  parameter int DLT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [DLT_W-1:0] inc_i,
  input  logic [DLT_W-1:0] dec_i,
  input  logic [CNT_W-1:0] cfg_hi_i,
  input  logic [CNT_W-1:0] cfg_lo_i,
  output logic             wm_o,
  output logic             change_o,
  output logic             underflow_o,
  output logic             overflow_o
);

  localparam int PAD = CNT_W + 1 - DLT_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   inc_ext, dec_ext, up, net;
  wm_state_e        state_q, state_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    inc_ext     = {{PAD{1'b0}}, inc_i};
    dec_ext     = {{PAD{1'b0}}, dec_i};
    up          = {1'b0, cnt_q} + inc_ext;
    net         = up - dec_ext;
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    if (dec_ext > up) begin
      cnt_d       = '0;
      underflow_o = 1'b1;
    end else if (net[CNT_W]) begin
      cnt_d      = '1;
      overflow_o = 1'b1;
    end else begin
      cnt_d = net[CNT_W-1:0];
    end
  end

  // The hi compare wins, so a misconfigured lo >= hi never clears a count at or above hi.
  always_comb begin
    state_d = state_q;
    if (cnt_q >= cfg_hi_i) begin
      state_d = CONGESTED;
    end else if (state_q == CONGESTED && cnt_q <= cfg_lo_i) begin
      state_d = NORMAL;
    end
  end

  assign change_o = (state_d != state_q);
  assign wm_o     = (state_q == CONGESTED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching flop behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      state_q <= NORMAL;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/mby_gcm_rx_wm_gen.sv
// Shared-memory RX watermark generator: per-port and shared-pool hysteresis,
// sticky error flags and a periodic refresh of the broadcast to IGR.
module mby_gcm_rx_wm_gen
  import mby_gmm_pkg::*;
#(
  parameter int NUM_PORTS = GMM_NUM_PORTS,
  parameter int CNT_W     = GMM_CNT_W,
  parameter int DLT_W     = 4,
  parameter int REF_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alloc_valid,
  input  logic [$clog2(NUM_PORTS)-1:0]          alloc_port,
  input  logic [DLT_W-1:0]                      alloc_seg,
  input  logic                                  free_valid,
  input  logic [$clog2(NUM_PORTS)-1:0]          free_port,
  input  logic [DLT_W-1:0]                      free_seg,
  input  logic [CNT_W-1:0]                      cfg_port_hi,
  input  logic [CNT_W-1:0]                      cfg_port_lo,
  input  logic [CNT_W-1:0]                      cfg_shr_hi,
  input  logic [CNT_W-1:0]                      cfg_shr_lo,
  input  logic [REF_W-1:0]                      cfg_refresh,
  output logic [$bits(mby_cm_shared_mem_rx_wm_t)-1:0] rx_wm,
  output logic                                  err_underflow,
  output logic                                  err_overflow
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] port_wm, port_chg, port_unf, port_ovf;
  logic                 shr_wm, shr_chg, shr_unf, shr_ovf;
  logic [DLT_W-1:0]     shr_inc, shr_dec;
  logic                 ref_expire, valid_d, valid_q;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic                 err_unf_q, err_ovf_q;
  mby_cm_shared_mem_rx_wm_t rx_wm_s;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mby_gcm_wm_hyst #(.CNT_W(CNT_W), .DLT_W(DLT_W)) u_hyst (
      .clk         (clk),
      .rst_n_i     (rst),
      .inc_i       ((alloc_valid && alloc_port == PORT_W'(p)) ? alloc_seg : '0),
      .dec_i       ((free_valid && free_port == PORT_W'(p)) ? free_seg : '0),
      .cfg_hi_i    (cfg_port_hi),
      .cfg_lo_i    (cfg_port_lo),
      .wm_o        (port_wm[p]),
      .change_o    (port_chg[p]),
      .underflow_o (port_unf[p]),
      .overflow_o  (port_ovf[p])
    );
  end

  // The pool sees every event regardless of port, netting both deltas in one update.
  assign shr_inc = alloc_valid ? alloc_seg : '0;
  assign shr_dec = free_valid ? free_seg : '0;

  mby_gcm_wm_hyst #(.CNT_W(CNT_W), .DLT_W(DLT_W)) u_shr_hyst (
    .clk         (clk),
    .rst_n_i     (rst),
    .inc_i       (shr_inc),
    .dec_i       (shr_dec),
    .cfg_hi_i    (cfg_shr_hi),
    .cfg_lo_i    (cfg_shr_lo),
    .wm_o        (shr_wm),
    .change_o    (shr_chg),
    .underflow_o (shr_unf),
    .overflow_o  (shr_ovf)
  );

  // A count that reached 0 while refresh was disabled fires at once when re-enabled.
  assign ref_expire = (cfg_refresh != '0) && (ref_q <= REF_W'(1));
  assign valid_d    = (|port_chg) | shr_chg | ref_expire;

  always_comb begin
    ref_d = ref_q;
    if (valid_d) begin
      ref_d = cfg_refresh;
    end else if (ref_q != '0) begin
      ref_d = ref_q - REF_W'(1);
    end
  end

  // NOTE: reset is synchronous and active-low, sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ref_q     <= cfg_refresh;
      err_unf_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ref_q     <= ref_d;
      err_unf_q <= err_unf_q | (|port_unf) | shr_unf;
      err_ovf_q <= err_ovf_q | (|port_ovf) | shr_ovf;
    end
  end

  always_comb begin
    rx_wm_s           = '0;
    rx_wm_s.valid     = valid_q;
    rx_wm_s.port_wm   = port_wm;
    rx_wm_s.shared_wm = shr_wm;
  end

  assign rx_wm         = rx_wm_s;
  assign err_underflow = err_unf_q;
  assign err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_mby_gcm_rx_wm_gen.sv
// Directed bench for the RX watermark generator: a vector table for the
// single-event cases plus sequences for back-to-back, refresh, overflow and reset.
module tb_mby_gcm_rx_wm_gen;
  import mby_gmm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, free_valid;
  logic [3:0]  alloc_port, free_port, alloc_seg, free_seg;
  logic [15:0] cfg_port_hi, cfg_port_lo, cfg_shr_hi, cfg_shr_lo, cfg_refresh;
  logic [17:0] rx_wm;
  logic        err_underflow, err_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mby_gcm_rx_wm_gen dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_port   (alloc_port),
    .alloc_seg    (alloc_seg),
    .free_valid   (free_valid),
    .free_port    (free_port),
    .free_seg     (free_seg),
    .cfg_port_hi  (cfg_port_hi),
    .cfg_port_lo  (cfg_port_lo),
    .cfg_shr_hi   (cfg_shr_hi),
    .cfg_shr_lo   (cfg_shr_lo),
    .cfg_refresh  (cfg_refresh),
    .rx_wm        (rx_wm),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow)
  );

  typedef struct {
    string       name;
    logic        av;
    logic [3:0]  ap;
    logic [3:0]  as;
    logic        fv;
    logic [3:0]  fp;
    logic [3:0]  fs;
    logic [15:0] wm;
    logic        shr;
    logic        vld;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wmw(input logic v, input logic [15:0] w, input logic s);
    return {14'b0, v, w, s};
  endfunction

  task automatic drive(input logic av, input logic [3:0] ap, input logic [3:0] as,
                       input logic fv, input logic [3:0] fp, input logic [3:0] fs);
    alloc_valid = av; alloc_port = ap; alloc_seg = as;
    free_valid  = fv; free_port  = fp; free_seg  = fs;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic add_vec(input string name, input logic av, input logic [3:0] ap, input logic [3:0] as,
                         input logic fv, input logic [3:0] fp, input logic [3:0] fs,
                         input logic [15:0] wm, input logic shr, input logic vld, input logic unf);
    vec_t v;
    v.name = name; v.av = av; v.ap = ap; v.as = as; v.fv = fv; v.fp = fp; v.fs = fs;
    v.wm = wm; v.shr = shr; v.vld = vld; v.unf = unf;
    vecs.push_back(v);
  endtask

  // Advance on falling edges until valid is seen or the budget runs out.
  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_wm[17] && n < maxc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    rst = 1'b0;
    idle();
    cfg_port_hi = 16'd8;  cfg_port_lo = 16'd4;
    cfg_shr_hi  = 16'd20; cfg_shr_lo  = 16'd10;
    cfg_refresh = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_rx_wm", {14'b0, rx_wm}, wmw(1'b0, 16'h0000, 1'b0));
    check("reset_err", {30'b0, err_underflow, err_overflow}, 32'd0);

    // Three back-to-back allocates: the pulse lands exactly 2 cycles after the last.
    drive(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    idle();
    check("b2b_n1", {14'b0, rx_wm}, wmw(1'b0, 16'h0000, 1'b0));
    @(negedge clk);
    check("b2b_n2", {14'b0, rx_wm}, wmw(1'b1, 16'h0008, 1'b0));
    @(negedge clk);
    check("b2b_n3", {14'b0, rx_wm}, wmw(1'b0, 16'h0008, 1'b0));
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 4'd9);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("b2b_clear", {14'b0, rx_wm}, wmw(1'b1, 16'h0000, 1'b0));
    @(negedge clk);

    //       name        av ap  as   fv fp  fs   port_wm  shr  vld  unf
    add_vec("set_a1",    1, 2,  3,   0, 0,  0,   16'h0000, 0,  0,   0);
    add_vec("set_a2",    1, 2,  3,   0, 0,  0,   16'h0000, 0,  0,   0);
    add_vec("set_a3",    1, 2,  3,   0, 0,  0,   16'h0004, 0,  1,   0);
    add_vec("hyst_f3",   0, 0,  0,   1, 2,  3,   16'h0004, 0,  0,   0);
    add_vec("hyst_f2",   0, 0,  0,   1, 2,  2,   16'h0000, 0,  1,   0);
    add_vec("coll_pre",  1, 7,  7,   0, 0,  0,   16'h0000, 0,  0,   0);
    add_vec("coll",      1, 7,  5,   1, 7,  5,   16'h0000, 0,  0,   0);
    add_vec("unf_pre",   1, 0,  1,   0, 0,  0,   16'h0000, 0,  0,   0);
    add_vec("unf",       0, 0,  0,   1, 0,  2,   16'h0000, 0,  0,   1);
    add_vec("unf_hold",  1, 0,  8,   0, 0,  0,   16'h0001, 0,  1,   1);
    add_vec("shr_set",   1, 1,  2,   0, 0,  0,   16'h0001, 1,  1,   1);
    add_vec("shr_hold",  0, 0,  0,   1, 7,  7,   16'h0001, 1,  0,   1);
    add_vec("both_clr",  0, 0,  0,   1, 0,  4,   16'h0000, 0,  1,   1);
    add_vec("mixed",     1, 15, 9,   1, 2,  4,   16'h8000, 0,  1,   1);

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ap, vecs[i].as, vecs[i].fv, vecs[i].fp, vecs[i].fs);
      @(negedge clk);
      idle();
      @(negedge clk);
      check({vecs[i].name, "_rx_wm"}, {14'b0, rx_wm}, wmw(vecs[i].vld, vecs[i].wm, vecs[i].shr));
      check({vecs[i].name, "_err"}, {30'b0, err_underflow, err_overflow}, {30'b0, vecs[i].unf, 1'b0});
    end

    // Refresh: period of 10, then a state change 4 cycles in restarts the interval.
    cfg_refresh = 16'd10;
    wait_valid(20, n);
    check("ref_first", {31'b0, rx_wm[17]}, 32'd1);
    wait_valid(30, n);
    check("ref_period1", n, 32'd10);
    wait_valid(30, n);
    check("ref_period2", n, 32'd10);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 4'd1, 4'd6, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    idle();
    check("ref_chg_n3", {31'b0, rx_wm[17]}, 32'd0);
    @(negedge clk);
    check("ref_chg_n4", {14'b0, rx_wm}, wmw(1'b1, 16'h8002, 1'b1));
    wait_valid(30, n);
    check("ref_restart", n, 32'd10);
    cfg_refresh = 16'd0;
    wait_valid(25, n);
    check("ref_disabled", {31'b0, rx_wm[17]}, 32'd0);

    // Overflow: 4370 x 15 segments exceeds 65535 on port 5 and on the pool.
    drive(1'b1, 4'd5, 4'd15, 1'b0, 4'd0, 4'd0);
    repeat (4370) @(negedge clk);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("ovf_rx_wm", {14'b0, rx_wm}, wmw(1'b0, 16'h8022, 1'b1));
    check("ovf_err", {30'b0, err_underflow, err_overflow}, 32'd3);

    // Mid-operation reset with an allocate in flight that must be discarded.
    rst = 1'b0;
    drive(1'b1, 4'd1, 4'd8, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    check("rst2_rx_wm", {14'b0, rx_wm}, wmw(1'b0, 16'h0000, 1'b0));
    check("rst2_err", {30'b0, err_underflow, err_overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst2_discard", {14'b0, rx_wm}, wmw(1'b0, 16'h0000, 1'b0));
    drive(1'b1, 4'd1, 4'd7, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("rst2_cnt7", {14'b0, rx_wm}, wmw(1'b0, 16'h0000, 1'b0));
    drive(1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("rst2_cnt8", {14'b0, rx_wm}, wmw(1'b1, 16'h0002, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mby_gcm_rx_wm_gen.md
# mby_gcm_rx_wm_gen

Watermark generator in the GCM that produces the shared-memory RX watermark broadcast (`mby_cm_shared_mem_rx_wm_t`) consumed by IGR. It tracks per-RX-port and total shared-memory segment usage from allocate/free events. Each port and the shared pool have their own hysteresis state machine. A registered watermark update is emitted on every state change and on a periodic refresh.

## Interface
- `NUM_PORTS`, 16: number of RX ports tracked; sets the width of the port watermark vector.
- `CNT_W`, 16: width of the usage counters, in segments.
- `DLT_W`, 4: width of the segment delta per event.
- `REF_W`, 16: width of the refresh period.
- `clk`  in  1  block clock.
- `rst`  in  1  synchronous, active-low reset.
- `alloc_valid`  in  1  allocate event.
- `alloc_port`  in  $clog2(NUM_PORTS)  port charged by the allocate.
- `alloc_seg`  in  DLT_W  segments allocated; 0 is legal and is a no-op.
- `free_valid`  in  1  free event.
- `free_port`  in  $clog2(NUM_PORTS)  port credited by the free.
- `free_seg`  in  DLT_W  segments freed.
- `cfg_port_hi`, `cfg_port_lo`  in  CNT_W  per-port set and clear thresholds, common to all ports.
- `cfg_shr_hi`, `cfg_shr_lo`  in  CNT_W  shared-pool set and clear thresholds.
- `cfg_refresh`  in  REF_W  refresh period in cycles; 0 disables refresh.
- `rx_wm`  out  $bits(mby_cm_shared_mem_rx_wm_t)  watermark struct with fields `valid`, `port_wm[NUM_PORTS-1:0]`, `shared_wm`.
- `err_underflow`  out  1  sticky flag: a free exceeded the counter.
- `err_overflow`  out  1  sticky flag: an allocate saturated a counter.

## Operation
- **Counters.** Each port counter is updated as `cnt[p] += alloc_seg` if alloc hits p, and `-= free_seg` if free hits p.
  - When alloc and free target the same port in the same cycle, the net delta is applied in a single update.
  - The shared counter applies the sum of both deltas in the same way.
  - The arithmetic is performed at CNT_W+1 bits.
  - A result below 0 saturates to 0 and sets `err_underflow`.
  - A result above 2^CNT_W−1 saturates to the maximum and sets `err_overflow`.
  - Both flags clear only on reset.
- **Hysteresis FSM, one per port plus one for the shared pool.** States are NORMAL (0) and CONGESTED (1).
  - NORMAL → CONGESTED when `cnt >= hi`.
  - CONGESTED → NORMAL when `cnt <= lo`.
  - Otherwise the state holds.
  - If lo ≥ hi by misconfiguration, the comparison evaluates hi first. A counter at or above hi is therefore always CONGESTED.
- **Broadcast.** `rx_wm.port_wm` and `rx_wm.shared_wm` always reflect the current FSM states.
  - `rx_wm.valid` pulses for 1 cycle when any FSM changes state, or when the refresh counter expires.
  - A change and an expiry in the same cycle produce a single pulse.
  - Any pulse reloads the refresh counter to `cfg_refresh`.
- **Config changes** take effect at the next compare. They do not retroactively generate events.

## Timing
- Reset values:
  - all counters 0;
  - all FSMs NORMAL;
  - `rx_wm` all-zero, including `valid` = 0;
  - error flags 0;
  - refresh counter loaded with `cfg_refresh`.
- Pipeline:
  - An event sampled at cycle N updates the counters at the N+1 edge.
  - The compare and the FSM/`rx_wm` register update at N+2, so threshold-to-output latency is 2 cycles.
  - `valid` is asserted in cycle N+2.
- Back-to-back events on consecutive cycles are accepted with no stall. There is no backpressure.
- Refresh with `cfg_refresh` = R: `valid` pulses every R cycles while no state change occurs. R = 1 gives `valid` every cycle.
- Reset asserted mid-operation discards in-flight events. Outputs return to reset values on the next edge.

## Structure
- `mby_gmm_pkg` holds:
  - `mby_cm_shared_mem_rx_wm_t`;
  - the localparams for `NUM_PORTS` and `CNT_W` defaults;
  - a `wm_state_e` enum (NORMAL, CONGESTED).
- Sub-module `mby_gcm_wm_hyst` contains one saturating counter, one hysteresis FSM and one change output.
  - It is instantiated NUM_PORTS+1 times.
  - The top level does event decode, shared-delta summation, refresh and struct packing.

## Test plan
- **Set threshold.** `port_hi`=8, `lo`=4: allocate 3 segments ×3 to port 2.
  - Expected: `port_wm[2]`=1, with a `valid` pulse 2 cycles after the third allocate.
  - Expected: the counter reads 9.
- **Hysteresis.** From the previous state, free 3 segments (counter 6).
  - Expected: no pulse and `port_wm[2]` stays 1.
  - Free 2 more (counter 4). Expected: `port_wm[2]`=0 and a pulse.
- **Same-port collision.** Alloc 5 and free 5 to port 7 in the same cycle, counter at 7, `hi`=8.
  - Expected: the counter stays 7, no pulse, no errors.
- **Underflow.** Free 2 from port 0 with counter 1.
  - Expected: the counter is 0 and `err_underflow`=1, holding until reset.
- **Refresh.** `cfg_refresh`=10 with idle traffic.
  - Expected: `valid` pulses exactly every 10 cycles.
  - A state change at refresh cycle 4 causes a pulse and restarts the 10-cycle interval.
- **Shared pool and reset.** `shr_hi`=20: allocate 15 segments to each of ports 0 and 1.
  - Expected: `shared_wm`=1.
  - Assert `rst` low for 1 cycle. Expected: all counters, `rx_wm` and error flags return to 0.
